// File: rtl/hit_reporter_pkg.sv
// Shared types and constants for the hit reporter.
// The hit record is sized to the widest lane/score it supports.
package hit_reporter_pkg;

  localparam int QUERY_ID_W  = 16;
  localparam int COL_W       = 32;
  localparam int PE_MAX_W    = 16;
  localparam int SCORE_MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic [QUERY_ID_W-1:0]  query_id;
    logic [PE_MAX_W-1:0]    pe;
    logic [COL_W-1:0]       col;
    logic [SCORE_MAX_W-1:0] score;
  } hit_t;

endpackage

// File: rtl/hit_reporter_if.sv
// Hit record stream: producer drives the record, consumer drives rdy.
// count travels alongside as a status word.
interface hit_reporter_if #(
  parameter int PE_W  = 6,
  parameter int WIDTH = 10
);
  import hit_reporter_pkg::*;

  logic                  hit_valid;
  logic                  hit_rdy;
  logic [QUERY_ID_W-1:0] query_id;
  logic [PE_W-1:0]       pe;
  logic [COL_W-1:0]      col;
  logic [WIDTH-1:0]      score;
  logic [31:0]           count;

  modport master (
    output hit_valid, query_id, pe, col, score, count,
    input  hit_rdy
  );

  modport slave (
    input  hit_valid, query_id, pe, col, score, count,
    output hit_rdy
  );
endinterface

// File: rtl/hit_reporter_hit_fifo.sv
// First-word-fall-through FIFO for hit records.
// flush empties it in one cycle and wins over push/pop.
module hit_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/hit_reporter.sv
// Captures systolic output columns and serialises flagged lanes
// into a hit FIFO, lowest lane first, stalling upstream meanwhile.
module hit_reporter
  import hit_reporter_pkg::*;
#(
  parameter int NUM_PES    = 64,
  parameter int WIDTH      = 10,
  parameter int FIFO_DEPTH = 16,
  localparam int PE_W = (NUM_PES > 1) ? $clog2(NUM_PES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [QUERY_ID_W-1:0]    query_id_in,
  input  logic                     valid_in,
  input  logic [NUM_PES*WIDTH-1:0] V_in,
  input  logic [NUM_PES-1:0]       high_score_in,
  output logic                     stall_out,
  output logic                     hit_valid_out,
  input  logic                     hit_rdy_in,
  output logic [QUERY_ID_W-1:0]    hit_query_id_out,
  output logic [PE_W-1:0]          hit_pe_out,
  output logic [COL_W-1:0]         hit_col_out,
  output logic [WIDTH-1:0]         hit_score_out,
  output logic [31:0]              hit_count_out
);

  state_t                   state;
  state_t                   state_n;
  logic [NUM_PES*WIDTH-1:0] pend_v;
  logic [NUM_PES-1:0]       pend_f;
  logic [COL_W-1:0]         pend_col;
  logic [COL_W-1:0]         col_cnt;
  logic [QUERY_ID_W-1:0]    qid;
  logic [31:0]              hit_count;

  logic [PE_W-1:0]          sel;
  logic [NUM_PES-1:0]       rest;
  logic                     last;
  logic                     push;
  logic                     capture;
  logic                     full;
  logic                     empty;
  hit_t                     rec;
  hit_t                     head;
  logic                     unused_bits;

  // Lowest set pending flag wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_PES - 1; i >= 0; i--) begin
      if (pend_f[i]) sel = PE_W'(i);
    end
  end

  assign rest    = pend_f & ~(NUM_PES'(1) << sel);
  assign last    = ~|rest;
  assign push    = (state == SCAN) && !full && !start_in;
  assign capture = (state == IDLE) && valid_in && !start_in;

  always_comb begin
    rec          = '0;
    rec.query_id = qid;
    rec.pe[PE_W-1:0] = sel;
    rec.col      = pend_col;
    rec.score[WIDTH-1:0] = pend_v[int'(sel)*WIDTH +: WIDTH];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (capture && |high_score_in) state_n = SCAN;
      SCAN: if (push && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start_in) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v    <= '0;
      pend_f    <= '0;
      pend_col  <= '0;
      col_cnt   <= '0;
      qid       <= '0;
      hit_count <= '0;
    end else if (start_in) begin
      pend_f    <= '0;
      col_cnt   <= '0;
      qid       <= query_id_in;
      hit_count <= '0;
    end else if (capture) begin
      pend_v   <= V_in;
      pend_f   <= high_score_in;
      pend_col <= col_cnt;
      col_cnt  <= col_cnt + 1'b1;
    end else if (push) begin
      pend_f <= rest;
      if (hit_count != '1) hit_count <= hit_count + 1'b1;
    end
  end

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (hit_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_in),
    .push  (push),
    .din   (rec),
    .pop   (hit_valid_out && hit_rdy_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Gating on empty keeps every data output at zero through reset.
  assign stall_out        = state == SCAN;
  assign hit_valid_out    = !empty;
  assign hit_query_id_out = empty ? '0 : head.query_id;
  assign hit_pe_out       = empty ? '0 : head.pe[PE_W-1:0];
  assign hit_col_out      = empty ? '0 : head.col;
  assign hit_score_out    = empty ? '0 : head.score[WIDTH-1:0];
  assign hit_count_out    = hit_count;
  assign unused_bits      = ^{head.pe, head.score};

endmodule

// File: tb/tb_hit_reporter.sv
// Scoreboard bench for hit_reporter: directed columns push expected
// hits, a negedge monitor pops and compares each accepted record.
module tb_hit_reporter;
  import hit_reporter_pkg::*;

  localparam int NP = 64;
  localparam int W  = 10;
  localparam int PW = 6;

  typedef struct {
    logic [15:0]   id;
    logic [PW-1:0] pe;
    logic [31:0]   col;
    logic [W-1:0]  score;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_in = 1'b0;
  logic [15:0]     query_id_in = '0;
  logic            valid_in = 1'b0;
  logic [NP*W-1:0] V_in = '0;
  logic [NP-1:0]   high_score_in = '0;
  logic            stall_out;

  hit_reporter_if #(.PE_W(PW), .WIDTH(W)) hif ();

  hit_reporter #(.NUM_PES(NP), .WIDTH(W), .FIFO_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .query_id_in      (query_id_in),
    .valid_in         (valid_in),
    .V_in             (V_in),
    .high_score_in    (high_score_in),
    .stall_out        (stall_out),
    .hit_valid_out    (hif.hit_valid),
    .hit_rdy_in       (hif.hit_rdy),
    .hit_query_id_out (hif.query_id),
    .hit_pe_out       (hif.pe),
    .hit_col_out      (hif.col),
    .hit_score_out    (hif.score),
    .hit_count_out    (hif.count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  exp_t        sb[$];
  logic [15:0] m_qid = '0;
  logic [31:0] m_col = '0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && hif.hit_valid && hif.hit_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_hit: got pe %0d score %0d expected none",
                 hif.pe, hif.score);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hif.query_id !== e.id || hif.pe !== e.pe ||
            hif.col !== e.col || hif.score !== e.score) begin
          fails++;
          $display("FAIL hit_rec: got id %0h pe %0d col %0d score %0d expected id %0h pe %0d col %0d score %0d",
                   hif.query_id, hif.pe, hif.col, hif.score,
                   e.id, e.pe, e.col, e.score);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] id);
    start_in    = 1'b1;
    query_id_in = id;
    step();
    start_in = 1'b0;
    sb.delete();
    m_qid = id;
    m_col = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall_out && n < 200) begin
      step();
      n++;
    end
    if (stall_out) chk("idle_timeout", 64'(stall_out), 64'd0);
  endtask

  task automatic send_col(input logic [NP-1:0] f, input logic [NP*W-1:0] v);
    wait_idle();
    valid_in      = 1'b1;
    high_score_in = f;
    V_in          = v;
    for (int i = 0; i < NP; i++) begin
      if (f[i]) sb.push_back('{m_qid, PW'(i), m_col, v[i*W +: W]});
    end
    m_col++;
    step();
    valid_in      = 1'b0;
    high_score_in = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      step();
      n++;
    end
    step();
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  logic [NP*W-1:0] v;
  logic [NP-1:0]   f;
  int              sc;

  initial begin
    hif.hit_rdy = 1'b1;
    #12;
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_valid", 64'(hif.hit_valid), 64'd0);
    chk("rst_count", 64'(hif.count), 64'd0);
    chk("rst_data", 64'({hif.query_id, hif.pe, hif.score}), 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    step();

    do_start(16'h0042);
    send_col('0, '0);
    step();
    chk("zero_flags_stall", 64'(stall_out), 64'd0);
    chk("zero_flags_valid", 64'(hif.hit_valid), 64'd0);
    v = '0;
    v[3*W +: W] = 10'd5; v[17*W +: W] = 10'd9; v[63*W +: W] = 10'd1023;
    f = '0; f[3] = 1'b1; f[17] = 1'b1; f[63] = 1'b1;
    send_col(f, v);
    drain();

    do_start(16'h0042);
    send_col(f, v);
    sc = 0;
    repeat (6) begin
      @(negedge clk);
      if (stall_out) sc++;
    end
    chk("stall_cycles", 64'(sc), 64'd3);
    drain();
    chk("count_3", 64'(hif.count), 64'd3);

    hif.hit_rdy = 1'b0;
    do_start(16'h0007);
    v = '0; f = '0;
    for (int i = 0; i < 20; i++) begin
      f[i] = 1'b1;
      v[i*W +: W] = W'(100 + i);
    end
    send_col(f, v);
    repeat (30) step();
    chk("full_count", 64'(hif.count), 64'd16);
    chk("full_stall", 64'(stall_out), 64'd1);
    chk("full_valid", 64'(hif.hit_valid), 64'd1);
    hif.hit_rdy = 1'b1;
    drain();
    chk("count_20", 64'(hif.count), 64'd20);
    chk("drained_stall", 64'(stall_out), 64'd0);

    hif.hit_rdy = 1'b0;
    do_start(16'h0009);
    v = '0; f = '0;
    for (int i = 0; i < 10; i++) begin
      f[i] = 1'b1;
      v[i*W +: W] = W'(7 * i + 1);
    end
    send_col(f, v);
    repeat (5) step();
    chk("queued_5", 64'(hif.count), 64'd5);
    do_start(16'h0011);
    chk("flush_valid", 64'(hif.hit_valid), 64'd0);
    chk("flush_count", 64'(hif.count), 64'd0);
    chk("flush_stall", 64'(stall_out), 64'd0);

    start_in = 1'b1; query_id_in = 16'h0033;
    valid_in = 1'b1; high_score_in = '0; high_score_in[2] = 1'b1;
    step();
    start_in = 1'b0; valid_in = 1'b0; high_score_in = '0;
    sb.delete(); m_qid = 16'h0033; m_col = '0;
    step();
    chk("drop_stall", 64'(stall_out), 64'd0);
    chk("drop_valid", 64'(hif.hit_valid), 64'd0);
    hif.hit_rdy = 1'b1;
    v = '0; v[5*W +: W] = 10'd77;
    f = '0; f[5] = 1'b1;
    send_col(f, v);
    drain();
    chk("drop_count", 64'(hif.count), 64'd1);

    hif.hit_rdy = 1'b0;
    v = '0; f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i * 8] = 1'b1;
      v[i*8*W +: W] = W'(i + 300);
    end
    send_col(f, v);
    repeat (3) step();
    #3 rst = 1'b0;
    #1;
    chk("arst_stall", 64'(stall_out), 64'd0);
    chk("arst_valid", 64'(hif.hit_valid), 64'd0);
    chk("arst_count", 64'(hif.count), 64'd0);
    chk("arst_data", 64'({hif.pe, hif.score}), 64'd0);
    sb.delete(); m_qid = '0; m_col = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    hif.hit_rdy = 1'b1;
    step();
    v = '0; v[1*W +: W] = 10'd512;
    f = '0; f[1] = 1'b1;
    send_col(f, v);
    drain();
    chk("post_rst_count", 64'(hif.count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/hit_reporter.md
HIT_REPORTER -- requirements
Module: hit_reporter

Interface
REQ-001 SHALL have parameter NUM_PES, default 64: PE lanes per score vector.
REQ-002 SHALL have parameter WIDTH, default 10: cell score width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: hit FIFO entries, power of two.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain for all logic.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_in  input  1  new query: flush state and latch query_id_in.
REQ-007 SHALL have port query_id_in  input  16  query ID #, sampled on start_in.
REQ-008 SHALL have port valid_in  input  1  V_in/high_score_in hold one systolic output column.
REQ-009 SHALL have port V_in  input  NUM_PES*WIDTH  cell scores, lane i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port high_score_in  input  NUM_PES  per-lane high-score flags.
REQ-011 SHALL have port stall_out  input-side control  output  1  upstream must hold its data and not advance.
REQ-012 SHALL have port hit_valid_out  output  1  hit record available.
REQ-013 SHALL have port hit_rdy_in  input  1  consumer accepts hit record.
REQ-014 SHALL have port hit_query_id_out  output  16  query ID of the hit.
REQ-015 SHALL have port hit_pe_out  output  clog2(NUM_PES)  lane index of the hit.
REQ-016 SHALL have port hit_col_out  output  32  column index of the hit within the query.
REQ-017 SHALL have port hit_score_out  output  WIDTH  cell score of the hit.
REQ-018 SHALL have port hit_count_out  output  32  hits pushed since start_in, saturating at 2^32-1.

Function
REQ-019 SHALL implement states IDLE and SCAN; stall_out SHALL be 1 exactly when state==SCAN.
REQ-020 In IDLE, valid_in=1 SHALL capture V_in, high_score_in and col_cnt into pending registers and increment col_cnt by 1 (wraps mod 2^32).
REQ-021 A capture with nonzero flags SHALL enter SCAN next cycle; a capture with all-zero flags SHALL stay in IDLE.
REQ-022 In SCAN, each cycle the FIFO is not full, the lowest-indexed set pending flag SHALL be pushed as {query_id, lane, col, score} and cleared.
REQ-023 In SCAN with the FIFO full, no push and no flag clear SHALL occur; the state is held.
REQ-024 SCAN SHALL return to IDLE on the edge that clears the last pending flag; valid_in SHALL be ignored while in SCAN.
REQ-025 Latency: for a capture at edge E with k flags and no backpressure, pushes SHALL occur at edges E+1..E+k and IDLE SHALL resume at E+k.
REQ-026 The FIFO SHALL be first-word-fall-through; hit_valid_out=!empty; a pop SHALL occur on hit_valid_out&&hit_rdy_in.
REQ-027 Push and pop in the same cycle SHALL both occur; full is evaluated on the registered count before the pop.
REQ-028 start_in SHALL, in one cycle, flush the FIFO, clear the pending flags, set col_cnt and hit_count_out to 0, latch query_id_in, and force IDLE.
REQ-029 When start_in and valid_in are both 1, start_in SHALL win and that valid_in SHALL be dropped.
REQ-030 Output fields SHALL stay stable while hit_valid_out=1 and hit_rdy_in=0.

Reset
REQ-031 Asserting rst (low) SHALL asynchronously force IDLE, an empty FIFO, stall_out=0, hit_valid_out=0, hit_count_out=0, col_cnt=0, the latched query ID to 0 and the pending flags to 0.
REQ-032 Reset mid-SCAN SHALL discard all pending and queued hits with no partial output.
REQ-033 All data outputs SHALL read 0 while in reset.

Structure
REQ-034 A shared package SHALL hold the hit-record struct, the QUERY_ID_W=16 and COL_W=32 constants, and the state enum.
REQ-035 The FIFO SHALL be a sub-module named hit_fifo: parameterised on DEPTH and record type, with push/pop/full/empty/flush.
REQ-036 Lowest-set-bit selection SHALL be a combinational priority encoder inside hit_reporter.

Verification
REQ-037 start_in with query_id_in=0x0042, then one valid column with flags=0, SHALL produce no hit; the next capture SHALL carry col=1.
REQ-038 A column with flags on lanes 3, 17 and 63 and scores 5, 9 and 1023, with hit_rdy_in=1, SHALL emit (pe,score) = (3,5), (17,9), (63,1023) in order, each with col=0 and id 0x0042; stall_out SHALL be high for exactly 3 cycles.
REQ-039 With hit_rdy_in=0 and 20 flags set, 16 hits SHALL queue, stall_out SHALL hold, and raising hit_rdy_in SHALL drain all 20 hits without loss.
REQ-040 start_in asserted mid-SCAN with 5 hits queued SHALL give hit_valid_out=0 next cycle and hit_count_out=0.
REQ-041 start_in and valid_in together SHALL drop that column and leave col_cnt=0.
REQ-042 rst pulsed low asynchronously between clock edges during SCAN SHALL immediately give stall_out=0 and hit_valid_out=0.
